// File: rtl/stack_pkg.sv
// Shared definitions for the stacking-game controller: state encoding,
// coordinate width and the reset-centre helper.
package stack_pkg;

   localparam int unsigned COORD_W = 10;

   typedef enum logic [1:0] {
      MOVE  = 2'd0,
      PLACE = 2'd1,
      OVER  = 2'd2,
      WIN   = 2'd3
   } state_t;

   // Left edge that centres a block of width init_w between x_min and x_max.
   function automatic logic [COORD_W-1:0] reset_center(input int unsigned x_min,
                                                       input int unsigned x_max,
                                                       input int unsigned init_w);
      return COORD_W'((x_min + x_max - init_w) / 2);
   endfunction

endpackage

// File: rtl/stack_tick.sv
// Movement tick generator: one-clk-wide pulse every TICK_DIV clk cycles.
module stack_tick #(
   parameter int unsigned TICK_DIV = 250000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Free-running divider; tick is registered so it is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/stack_ctrl.sv
// Stacking-game controller: moves a block left/right within [X_MIN, X_MAX),
// places it on the previous layer trimming it to the overlap, and detects
// game over / win.
// Optional feature: define STACK_AUTO_SWING_EN to make the block swing
// back and forth on its own while no direction input is held.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int unsigned X_MIN      = 160,
   parameter int unsigned X_MAX      = 480,
   parameter int unsigned BASE_Y     = 360,
   parameter int unsigned BLOCK_H    = 20,
   parameter int unsigned INIT_W     = 64,
   parameter int unsigned MAX_LAYERS = 16,
   parameter int unsigned STEP       = 2,
   parameter int unsigned TICK_DIV   = 250000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               left,
   input  logic               right,
   input  logic               drop,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic [COORD_W-1:0] width,
   output logic [COORD_W-1:0] height,
   output logic [COORD_W-1:0] prev_x,
   output logic [COORD_W-1:0] prev_w,
   output logic               game_over,
   output logic               win
);

   localparam logic [COORD_W-1:0] CENTER   = reset_center(X_MIN, X_MAX, INIT_W);
   localparam logic [COORD_W-1:0] XMIN_C   = COORD_W'(X_MIN);
   localparam logic [COORD_W-1:0] XMAX_C   = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] INITW_C  = COORD_W'(INIT_W);
   localparam logic [COORD_W-1:0] BASEY_C  = COORD_W'(BASE_Y);
   localparam logic [COORD_W-1:0] BLKH_C   = COORD_W'(BLOCK_H);
   localparam logic [COORD_W-1:0] LAYERS_C = COORD_W'(MAX_LAYERS);
   localparam logic [COORD_W:0]   XMIN_W   = (COORD_W+1)'(X_MIN);
   localparam logic [COORD_W:0]   XMAX_W   = (COORD_W+1)'(X_MAX);
   localparam logic [COORD_W:0]   STEP_W   = (COORD_W+1)'(STEP);

   state_t             state;
   logic               drop_q;
   logic               tick;
   logic [COORD_W-1:0] left_pos;
   logic [COORD_W-1:0] right_pos;
   logic [COORD_W-1:0] mv_x;
   logic [COORD_W:0]   a_l, a_r, b_l, b_r, ov_l, ov_r, ov_w;
   logic               ov_ok;
   logic [COORD_W-1:0] height_nxt;
`ifdef STACK_AUTO_SWING_EN
   logic               dir;       // 1 = moving right
   logic               mv_dir;
`endif

   stack_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Screen y of the moving block sits one layer above the stack.
   always_comb begin
      pos_y = BASEY_C - (height + COORD_W'(1)) * BLKH_C;
   end

   // Saturated one-step candidates in each direction (11-bit compares).
   always_comb begin
      if ({1'b0, pos_x} < XMIN_W + STEP_W) left_pos = XMIN_C;
      else                                  left_pos = pos_x - STEP_C;
      if ({1'b0, pos_x} + {1'b0, width} + STEP_W > XMAX_W) right_pos = XMAX_C - width;
      else                                                  right_pos = pos_x + STEP_C;
   end

   // Position (and swing direction) to adopt on the next tick in MOVE.
   always_comb begin
      mv_x = pos_x;
`ifdef STACK_AUTO_SWING_EN
      mv_dir = dir;
`endif
      if (left && !right) begin
         mv_x = left_pos;
`ifdef STACK_AUTO_SWING_EN
         mv_dir = 1'b0;
`endif
      end else if (right && !left) begin
         mv_x = right_pos;
`ifdef STACK_AUTO_SWING_EN
         mv_dir = 1'b1;
`endif
      end
`ifdef STACK_AUTO_SWING_EN
      else if (!left && !right) begin
         // Direction flips on the step that lands on a bound.
         if (dir) begin
            mv_x = right_pos;
            if ({1'b0, right_pos} + {1'b0, width} == XMAX_W) mv_dir = 1'b0;
         end else begin
            mv_x = left_pos;
            if (left_pos == XMIN_C) mv_dir = 1'b1;
         end
      end
`endif
   end

   // Overlap of the moving block with the top placed layer.
   always_comb begin
      a_l   = {1'b0, pos_x};
      a_r   = a_l + {1'b0, width};
      b_l   = {1'b0, prev_x};
      b_r   = b_l + {1'b0, prev_w};
      ov_l  = (a_l > b_l) ? a_l : b_l;
      ov_r  = (a_r < b_r) ? a_r : b_r;
      ov_ok = (ov_r > ov_l);
      ov_w  = ov_r - ov_l;
      height_nxt = height + COORD_W'(1);
   end

   // Game FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MOVE;
         drop_q    <= 1'b0;
         pos_x     <= CENTER;
         prev_x    <= CENTER;
         width     <= INITW_C;
         prev_w    <= INITW_C;
         height    <= '0;
         game_over <= 1'b0;
         win       <= 1'b0;
`ifdef STACK_AUTO_SWING_EN
         dir       <= 1'b1;
`endif
      end else begin
         drop_q <= drop;
         case (state)
            MOVE: begin
               if (drop && !drop_q) begin
                  state <= PLACE;
               end else if (tick) begin
                  pos_x <= mv_x;
`ifdef STACK_AUTO_SWING_EN
                  dir   <= mv_dir;
`endif
               end
            end
            PLACE: begin
               if (!ov_ok) begin
                  state     <= OVER;
                  game_over <= 1'b1;
               end else begin
                  prev_x <= ov_l[COORD_W-1:0];
                  prev_w <= ov_w[COORD_W-1:0];
                  width  <= ov_w[COORD_W-1:0];
                  pos_x  <= ov_l[COORD_W-1:0];
                  height <= height_nxt;
                  if (height_nxt == LAYERS_C) begin
                     state <= WIN;
                     win   <= 1'b1;
                  end else begin
                     state <= MOVE;
                  end
               end
            end
            OVER:    state <= OVER;
            WIN:     state <= WIN;
            default: state <= MOVE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl (TICK_DIV=4).
// Define STACK_AUTO_SWING_EN to exercise the auto-swing build.
module tb_stack_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       left = 1'b0;
   logic       right = 1'b0;
   logic       drop = 1'b0;
   logic [9:0] pos_x, pos_y, width, height, prev_x, prev_w;
   logic       game_over, win;

   int total = 0;
   int bad = 0;

   stack_ctrl #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .left      (left),
      .right     (right),
      .drop      (drop),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .width     (width),
      .height    (height),
      .prev_x    (prev_x),
      .prev_w    (prev_w),
      .game_over (game_over),
      .win       (win)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      left = 1'b0; right = 1'b0; drop = 1'b0;
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   task automatic pulse_drop();
      drop = 1'b1;
      cycles(1);
      drop = 1'b0;
      cycles(3);
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (pos_x !== 10'd288) begin bad++; $display("FAIL reset_pos_x got=%0d exp=288", pos_x); end
      total++; if (width !== 10'd64) begin bad++; $display("FAIL reset_width got=%0d exp=64", width); end
      total++; if (height !== 10'd0) begin bad++; $display("FAIL reset_height got=%0d exp=0", height); end
      total++; if (pos_y !== 10'd340) begin bad++; $display("FAIL reset_pos_y got=%0d exp=340", pos_y); end
      total++; if ({prev_x, prev_w} !== {10'd288, 10'd64}) begin bad++; $display("FAIL reset_prev got=%0d/%0d exp=288/64", prev_x, prev_w); end
      total++; if ({game_over, win} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", game_over, win); end
   endtask

   task automatic test_hold();
      apply_reset();
      cycles(40);
      total++; if (pos_x !== 10'd288) begin bad++; $display("FAIL idle_hold got=%0d exp=288", pos_x); end
      left = 1'b1; right = 1'b1;
      cycles(40);
      left = 1'b0; right = 1'b0;
      cycles(1);
      total++; if (pos_x !== 10'd288) begin bad++; $display("FAIL both_hold got=%0d exp=288", pos_x); end
   endtask

   task automatic test_saturate();
      logic beyond;
      beyond = 1'b0;
      apply_reset();
      right = 1'b1;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (pos_x > 10'd416 || (11'(pos_x) + 11'(width)) > 11'd480) beyond = 1'b1;
      end
      right = 1'b0;
      cycles(1);
      total++; if (beyond !== 1'b0) begin bad++; $display("FAIL sat_never_beyond got=%b exp=0", beyond); end
      total++; if (pos_x !== 10'd416) begin bad++; $display("FAIL sat_right got=%0d exp=416", pos_x); end
   endtask

   task automatic test_place_offset();
      apply_reset();
      right = 1'b1;
      cycles(20);
      right = 1'b0;
      cycles(1);
      total++; if (pos_x !== 10'd298) begin bad++; $display("FAIL five_ticks got=%0d exp=298", pos_x); end
      pulse_drop();
      total++; if (width !== 10'd54) begin bad++; $display("FAIL place_width got=%0d exp=54", width); end
      total++; if (pos_x !== 10'd298) begin bad++; $display("FAIL place_pos_x got=%0d exp=298", pos_x); end
      total++; if (height !== 10'd1) begin bad++; $display("FAIL place_height got=%0d exp=1", height); end
      total++; if (pos_y !== 10'd320) begin bad++; $display("FAIL place_pos_y got=%0d exp=320", pos_y); end
      total++; if ({prev_x, prev_w} !== {10'd298, 10'd54}) begin bad++; $display("FAIL place_prev got=%0d/%0d exp=298/54", prev_x, prev_w); end
   endtask

   task automatic test_game_over();
      apply_reset();
      left = 1'b1;
      cycles(400);
      left = 1'b0;
      cycles(1);
      total++; if (pos_x !== 10'd160) begin bad++; $display("FAIL sat_left got=%0d exp=160", pos_x); end
      pulse_drop();
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_flag got=%b exp=1", game_over); end
      total++; if (height !== 10'd0) begin bad++; $display("FAIL over_height got=%0d exp=0", height); end
      right = 1'b1;
      for (int i = 0; i < 10; i++) pulse_drop();
      right = 1'b0;
      total++; if ({pos_x, height, game_over, win} !== {10'd160, 10'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL over_sticky got=%0d/%0d/%b/%b exp=160/0/1/0", pos_x, height, game_over, win);
      end
   endtask

   task automatic test_win();
      apply_reset();
      drop = 1'b1;
      cycles(50);
      drop = 1'b0;
      cycles(2);
      total++; if (height !== 10'd1) begin bad++; $display("FAIL held_drop got=%0d exp=1", height); end
      for (int i = 0; i < 14; i++) pulse_drop();
      total++; if ({height, win} !== {10'd15, 1'b0}) begin bad++; $display("FAIL pre_win got=%0d/%b exp=15/0", height, win); end
      pulse_drop();
      total++; if ({height, win, game_over} !== {10'd16, 1'b1, 1'b0}) begin
         bad++; $display("FAIL win got=%0d/%b/%b exp=16/1/0", height, win, game_over);
      end
      total++; if ({width, pos_y} !== {10'd64, 10'd20}) begin bad++; $display("FAIL win_geom got=%0d/%0d exp=64/20", width, pos_y); end
      right = 1'b1;
      for (int i = 0; i < 10; i++) pulse_drop();
      right = 1'b0;
      total++; if ({pos_x, height, win} !== {10'd288, 10'd16, 1'b1}) begin
         bad++; $display("FAIL win_sticky got=%0d/%0d/%b exp=288/16/1", pos_x, height, win);
      end
   endtask

   task automatic test_reset_in_place();
      apply_reset();
      right = 1'b1;
      cycles(20);
      right = 1'b0;
      drop = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      total++; if ({pos_x, width, height} !== {10'd288, 10'd64, 10'd0}) begin
         bad++; $display("FAIL rst_in_place got=%0d/%0d/%0d exp=288/64/0", pos_x, width, height);
      end
      @(negedge clk);
      drop = 1'b0;
      rst = 1'b0;
      cycles(4);
      total++; if ({height, game_over} !== {10'd0, 1'b0}) begin
         bad++; $display("FAIL rst_no_partial got=%0d/%b exp=0/0", height, game_over);
      end
   endtask

`ifdef STACK_AUTO_SWING_EN
   task automatic test_swing();
      logic [9:0] last;
      int         n;
      logic       mono;
      apply_reset();
      mono = 1'b1; last = pos_x; n = 0;
      while (pos_x !== 10'd416 && n < 400) begin
         @(negedge clk); n++;
         if (pos_x < last) mono = 1'b0;
         last = pos_x;
      end
      total++; if (pos_x !== 10'd416 || !mono) begin bad++; $display("FAIL swing_up got=%0d mono=%b exp=416 mono=1", pos_x, mono); end
      n = 0;
      while (pos_x === 10'd416 && n < 10) begin @(negedge clk); n++; end
      total++; if (pos_x !== 10'd414) begin bad++; $display("FAIL swing_rev_r got=%0d exp=414", pos_x); end
      mono = 1'b1; last = pos_x; n = 0;
      while (pos_x !== 10'd160 && n < 600) begin
         @(negedge clk); n++;
         if (pos_x > last) mono = 1'b0;
         last = pos_x;
      end
      total++; if (pos_x !== 10'd160 || !mono) begin bad++; $display("FAIL swing_down got=%0d mono=%b exp=160 mono=1", pos_x, mono); end
      n = 0;
      while (pos_x === 10'd160 && n < 10) begin @(negedge clk); n++; end
      total++; if (pos_x !== 10'd162) begin bad++; $display("FAIL swing_rev_l got=%0d exp=162", pos_x); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef STACK_AUTO_SWING_EN
      test_swing();
`else
      test_hold();
      test_saturate();
      test_place_offset();
      test_game_over();
      test_win();
`endif
      test_reset_in_place();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
